// File: rtl/dispatch_int_pkg.sv
// dispatch_int_pkg
//   Shared integer-dispatch types and sizes: the micro-op record passed from
//   rename through dispatch into issue_queue_int, the register-source
//   encoding, and a tag-bus match helper.
//   No ports (package).
package dispatch_int_pkg;

  localparam int DISPATCH_WIDTH     = 4;
  localparam int ISSUE_WIDTH_INT    = 2;
  localparam int PRF_INT_SIZE       = 64;
  localparam int PRF_INT_INDEX_SIZE = 6;

  typedef enum logic [1:0] {
    RS_FROM_RF   = 2'd0,
    RS_FROM_IMM  = 2'd1,
    RS_FROM_PC   = 2'd2,
    RS_FROM_ZERO = 2'd3
  } rs_source_t;

  typedef struct packed {
    logic                          valid;
    logic                          rd_valid;
    logic [PRF_INT_INDEX_SIZE-1:0] rd_prf_int_index;
    logic [PRF_INT_INDEX_SIZE-1:0] rs1_prf_int_index;
    rs_source_t                    rs1_source;
    logic                          rs1_from_ctb;
    logic [PRF_INT_INDEX_SIZE-1:0] rs2_prf_int_index;
    rs_source_t                    rs2_source;
    logic                          rs2_from_ctb;
    logic [15:0]                   payload;
  } micro_op_t;

  // True when any valid common-tag-bus lane carries the given index.
  function automatic logic ctb_match(
    input logic [PRF_INT_INDEX_SIZE-1:0]                      idx,
    input logic [ISSUE_WIDTH_INT-1:0]                         tag_valid,
    input logic [ISSUE_WIDTH_INT-1:0][PRF_INT_INDEX_SIZE-1:0] tag_index
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH_INT; k++) begin
      if (tag_valid[k] && (tag_index[k] == idx)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/dispatch_int_busy_table.sv
// busy_table_int
//   One bit per integer physical register; 1 = value not yet broadcast on the
//   common tag bus. Register 0 is hardwired not-busy.
//   Ports:
//     clk_i, rst_ni  clock, asynchronous active-low reset (clears all bits)
//     set_valid_i / set_index_i   DISPATCH_WIDTH set ports (new destinations)
//     clr_valid_i / clr_index_i   ISSUE_WIDTH_INT clear ports (tag bus)
//     rd_index_i / rd_busy_o      2*DISPATCH_WIDTH read ports (registered state)
//   A set and a clear of the same index in one cycle leaves the bit set: the
//   clear belongs to the old producer, the set to the newly renamed one.
module busy_table_int
  import dispatch_int_pkg::*;
(
  input  logic                                               clk_i,
  input  logic                                               rst_ni,
  input  logic [DISPATCH_WIDTH-1:0]                          set_valid_i,
  input  logic [DISPATCH_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  set_index_i,
  input  logic [ISSUE_WIDTH_INT-1:0]                         clr_valid_i,
  input  logic [ISSUE_WIDTH_INT-1:0][PRF_INT_INDEX_SIZE-1:0] clr_index_i,
  input  logic [2*DISPATCH_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] rd_index_i,
  output logic [2*DISPATCH_WIDTH-1:0]                        rd_busy_o
);

  logic [PRF_INT_SIZE-1:0] busy_q;
  logic [PRF_INT_SIZE-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    // Clears first, sets afterwards, so a set overrides a same-cycle clear.
    for (int k = 0; k < ISSUE_WIDTH_INT; k++) begin
      if (clr_valid_i[k]) busy_d[clr_index_i[k]] = 1'b0;
    end
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (set_valid_i[i]) busy_d[set_index_i[i]] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  always_comb begin
    for (int r = 0; r < 2*DISPATCH_WIDTH; r++) begin
      rd_busy_o[r] = busy_q[rd_index_i[r]];
    end
  end

endmodule

// File: rtl/dispatch_int.sv
// dispatch_int
//   Registers one renamed group per cycle toward issue_queue_int, resolving
//   for each register source whether it must wait for a common-tag-bus
//   broadcast (rsN_from_ctb).
//   Ports:
//     clock               rising-edge clock
//     reset               asynchronous active-low reset
//     uop_in              renamed group (per-lane .valid)
//     in_ready            group on uop_in is taken this cycle
//     iq_int_full         issue queue cannot take a group this cycle
//     ctb_prf_int_index   tag-bus indices, ctb_valid per-lane valid
//     flush               synchronous flush: drop held and incoming group
//     uop_out             registered group to issue_queue_int
//   Handshake: a group on uop_out is consumed on every edge where it is valid
//   and iq_int_full=0; uop_in is taken on every edge where in_ready=1 and
//   any lane is valid. in_ready = ~out_valid | ~iq_int_full.
//   Build option: DISPATCH_INT_CTB_BYPASS_EN -- when defined, a tag-bus
//   broadcast in the loading cycle on a source index suppresses the busy
//   indication for that source; otherwise the registered busy table alone
//   decides and the issue slot catches the same-cycle broadcast.
module dispatch_int
  import dispatch_int_pkg::*;
(
  input  logic                                               clock,
  input  logic                                               reset,
  input  micro_op_t [DISPATCH_WIDTH-1:0]                     uop_in,
  output logic                                               in_ready,
  input  logic                                               iq_int_full,
  input  logic [ISSUE_WIDTH_INT-1:0][PRF_INT_INDEX_SIZE-1:0] ctb_prf_int_index,
  input  logic [ISSUE_WIDTH_INT-1:0]                         ctb_valid,
  input  logic                                               flush,
  output micro_op_t [DISPATCH_WIDTH-1:0]                     uop_out
);

  micro_op_t [DISPATCH_WIDTH-1:0] uop_out_q;
  micro_op_t [DISPATCH_WIDTH-1:0] uop_out_d;
  micro_op_t [DISPATCH_WIDTH-1:0] load_uop;
  micro_op_t [DISPATCH_WIDTH-1:0] hold_uop;

  logic                                                out_valid;
  logic                                                any_in_valid;
  logic                                                accept;
  logic                                                load_en;
  logic [DISPATCH_WIDTH-1:0]                           intra1;
  logic [DISPATCH_WIDTH-1:0]                           intra2;
  logic [DISPATCH_WIDTH-1:0]                           busy1;
  logic [DISPATCH_WIDTH-1:0]                           busy2;
  logic [DISPATCH_WIDTH-1:0]                           set_valid;
  logic [DISPATCH_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   set_index;
  logic [2*DISPATCH_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] rd_index;
  logic [2*DISPATCH_WIDTH-1:0]                         rd_busy;

  always_comb begin
    out_valid    = 1'b0;
    any_in_valid = 1'b0;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      out_valid    = out_valid | uop_out_q[j].valid;
      any_in_valid = any_in_valid | uop_in[j].valid;
    end
  end

  assign in_ready = ~out_valid | ~iq_int_full;
  assign accept   = in_ready & any_in_valid;
  // A flushed cycle discards the incoming group, including its busy sets.
  assign load_en  = accept & ~flush;

  always_comb begin
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      rd_index[2*j]   = uop_in[j].rs1_prf_int_index;
      rd_index[2*j+1] = uop_in[j].rs2_prf_int_index;
      set_valid[j]    = load_en & uop_in[j].valid & uop_in[j].rd_valid &
                        (uop_in[j].rd_prf_int_index != '0);
      set_index[j]    = uop_in[j].rd_prf_int_index;
    end
  end

  busy_table_int u_busy_table (
    .clk_i       (clock),
    .rst_ni      (reset),
    .set_valid_i (set_valid),
    .set_index_i (set_index),
    .clr_valid_i (ctb_valid),
    .clr_index_i (ctb_prf_int_index),
    .rd_index_i  (rd_index),
    .rd_busy_o   (rd_busy)
  );

  // Source resolution for the loading group. An older lane in the same group
  // that writes the source register makes it wait, whatever the table says,
  // because that destination is only being marked busy at this edge.
  always_comb begin
    load_uop = '0;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      intra1[j] = 1'b0;
      intra2[j] = 1'b0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if ((i < j) && uop_in[i].valid && uop_in[i].rd_valid &&
            (uop_in[i].rd_prf_int_index != '0)) begin
          if (uop_in[i].rd_prf_int_index == uop_in[j].rs1_prf_int_index) intra1[j] = 1'b1;
          if (uop_in[i].rd_prf_int_index == uop_in[j].rs2_prf_int_index) intra2[j] = 1'b1;
        end
      end
`ifdef DISPATCH_INT_CTB_BYPASS_EN
      busy1[j] = rd_busy[2*j] &
                 ~ctb_match(uop_in[j].rs1_prf_int_index, ctb_valid, ctb_prf_int_index);
      busy2[j] = rd_busy[2*j+1] &
                 ~ctb_match(uop_in[j].rs2_prf_int_index, ctb_valid, ctb_prf_int_index);
`else
      busy1[j] = rd_busy[2*j];
      busy2[j] = rd_busy[2*j+1];
`endif
      if (uop_in[j].valid) begin
        load_uop[j] = uop_in[j];
        load_uop[j].rs1_from_ctb = (uop_in[j].rs1_source == RS_FROM_RF) &&
                                   (uop_in[j].rs1_prf_int_index != '0) &&
                                   (busy1[j] || intra1[j]);
        load_uop[j].rs2_from_ctb = (uop_in[j].rs2_source == RS_FROM_RF) &&
                                   (uop_in[j].rs2_prf_int_index != '0) &&
                                   (busy2[j] || intra2[j]);
      end
    end
  end

  // Held group keeps snooping the tag bus so a broadcast during a stall is
  // not lost.
  always_comb begin
    hold_uop = uop_out_q;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      if (ctb_match(uop_out_q[j].rs1_prf_int_index, ctb_valid, ctb_prf_int_index))
        hold_uop[j].rs1_from_ctb = 1'b0;
      if (ctb_match(uop_out_q[j].rs2_prf_int_index, ctb_valid, ctb_prf_int_index))
        hold_uop[j].rs2_from_ctb = 1'b0;
    end
  end

  always_comb begin
    uop_out_d = hold_uop;
    if (flush)                          uop_out_d = '0;
    else if (accept)                    uop_out_d = load_uop;
    else if (out_valid && !iq_int_full) uop_out_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) uop_out_q <= '0;
    else        uop_out_q <= uop_out_d;
  end

  assign uop_out = uop_out_q;

endmodule

// File: tb/tb_dispatch_int.sv
module tb_dispatch_int;
  import dispatch_int_pkg::*;

  typedef logic [PRF_INT_INDEX_SIZE-1:0] idx_t;

  logic                                               clock;
  logic                                               reset;
  micro_op_t [DISPATCH_WIDTH-1:0]                     uop_in;
  logic                                               in_ready;
  logic                                               iq_int_full;
  logic [ISSUE_WIDTH_INT-1:0][PRF_INT_INDEX_SIZE-1:0] ctb_prf_int_index;
  logic [ISSUE_WIDTH_INT-1:0]                         ctb_valid;
  logic                                               flush;
  micro_op_t [DISPATCH_WIDTH-1:0]                     uop_out;

  int n_checks;
  int n_fail;

  dispatch_int dut (
    .clock             (clock),
    .reset             (reset),
    .uop_in            (uop_in),
    .in_ready          (in_ready),
    .iq_int_full       (iq_int_full),
    .ctb_prf_int_index (ctb_prf_int_index),
    .ctb_valid         (ctb_valid),
    .flush             (flush),
    .uop_out           (uop_out)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver helpers
  function automatic micro_op_t make_uop(input logic v, input logic rdv, input idx_t rd,
                                         input idx_t rs1, input rs_source_t s1,
                                         input idx_t rs2, input rs_source_t s2,
                                         input logic [15:0] pay);
    micro_op_t u;
    u = '0;
    u.valid = v;
    u.rd_valid = rdv;
    u.rd_prf_int_index = rd;
    u.rs1_prf_int_index = rs1;
    u.rs1_source = s1;
    u.rs2_prf_int_index = rs2;
    u.rs2_source = s2;
    u.payload = pay;
    return u;
  endfunction

  task automatic idle();
    uop_in = '0;
    ctb_valid = '0;
    ctb_prf_int_index = '0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle();
    iq_int_full = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    n_checks++;
    if (uop_out !== '0) begin
      n_fail++;
      $display("FAIL reset_uop_out: got %h want 0", uop_out);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_dep_busy();
    micro_op_t [DISPATCH_WIDTH-1:0] exp;
    idle();
    uop_in[0] = make_uop(1'b1, 1'b1, 6'd5, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0a01);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b1, 6'd5, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0a01);
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL dep_load_rd: got %h want %h", uop_out, exp);
    end
    idle();
    uop_in[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd5, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0a02);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd5, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0a02);
    exp[0].rs1_from_ctb = 1'b1;
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL dep_rs1_busy: got %h want %h", uop_out, exp);
    end
    idle();
    ctb_valid[0] = 1'b1;
    ctb_prf_int_index[0] = 6'd5;
    tick();
    n_checks++;
    if (uop_out !== '0) begin
      n_fail++;
      $display("FAIL dep_drain: got %h want 0", uop_out);
    end
    idle();
    uop_in[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd5, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0a03);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd5, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0a03);
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL dep_rs1_ready: got %h want %h", uop_out, exp);
    end
    idle();
    tick();
  endtask

  task automatic test_intra_group();
    micro_op_t [DISPATCH_WIDTH-1:0] exp;
    idle();
    uop_in[0] = make_uop(1'b1, 1'b1, 6'd7, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0b00);
    uop_in[1] = make_uop(1'b0, 1'b1, 6'd20, 6'd7, RS_FROM_RF, 6'd7, RS_FROM_RF, 16'hffff);
    uop_in[2] = make_uop(1'b1, 1'b0, 6'd0, 6'd0, RS_FROM_RF, 6'd7, RS_FROM_RF, 16'h0b02);
    uop_in[3] = make_uop(1'b1, 1'b0, 6'd0, 6'd7, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0b03);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b1, 6'd7, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0b00);
    exp[2] = make_uop(1'b1, 1'b0, 6'd0, 6'd0, RS_FROM_RF, 6'd7, RS_FROM_RF, 16'h0b02);
    exp[2].rs2_from_ctb = 1'b1;
    exp[3] = make_uop(1'b1, 1'b0, 6'd0, 6'd7, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0b03);
    exp[3].rs1_from_ctb = 1'b1;
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL intra_group: got %h want %h", uop_out, exp);
    end
    idle();
    ctb_valid[1] = 1'b1;
    ctb_prf_int_index[1] = 6'd7;
    tick();
    // p20 came from an invalid lane and p7 was broadcast: both ready.
    idle();
    uop_in[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd20, RS_FROM_RF, 6'd7, RS_FROM_RF, 16'h0b10);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd20, RS_FROM_RF, 6'd7, RS_FROM_RF, 16'h0b10);
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL intra_after: got %h want %h", uop_out, exp);
    end
    idle();
    tick();
  endtask

  task automatic test_stall_wakeup();
    micro_op_t [DISPATCH_WIDTH-1:0] exp;
    idle();
    uop_in[0] = make_uop(1'b1, 1'b1, 6'd9, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0c00);
    tick();
    idle();
    uop_in[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd9, RS_FROM_RF, 6'd0, RS_FROM_IMM, 16'h0c01);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd9, RS_FROM_RF, 6'd0, RS_FROM_IMM, 16'h0c01);
    exp[0].rs1_from_ctb = 1'b1;
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL stall_load: got %h want %h", uop_out, exp);
    end
    // stall cycle 1: offered group must be ignored
    idle();
    iq_int_full = 1'b1;
    uop_in[0] = make_uop(1'b1, 1'b1, 6'd11, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0cee);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_ready_c1: got %b want 0", in_ready);
    end
    tick();
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL stall_hold_c1: got %h want %h", uop_out, exp);
    end
    // stall cycle 2: broadcast p9
    ctb_valid[0] = 1'b1;
    ctb_prf_int_index[0] = 6'd9;
    tick();
    exp[0].rs1_from_ctb = 1'b0;
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL stall_wakeup_c2: got %h want %h", uop_out, exp);
    end
    // stall cycle 3
    ctb_valid = '0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_ready_c3: got %b want 0", in_ready);
    end
    tick();
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL stall_hold_c3: got %h want %h", uop_out, exp);
    end
    idle();
    iq_int_full = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b want 1", in_ready);
    end
    tick();
    n_checks++;
    if (uop_out !== '0) begin
      n_fail++;
      $display("FAIL stall_delivered: got %h want 0", uop_out);
    end
    // the rejected group must not have marked p11 busy
    uop_in[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd11, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0c02);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd11, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0c02);
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL stall_no_set: got %h want %h", uop_out, exp);
    end
    idle();
    tick();
  endtask

  task automatic test_set_wins();
    micro_op_t [DISPATCH_WIDTH-1:0] exp;
    idle();
    uop_in[1] = make_uop(1'b1, 1'b1, 6'd4, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0d00);
    ctb_valid[1] = 1'b1;
    ctb_prf_int_index[1] = 6'd4;
    tick();
    idle();
    uop_in[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd4, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0d01);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd4, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0d01);
    exp[0].rs1_from_ctb = 1'b1;
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL set_wins: got %h want %h", uop_out, exp);
    end
    idle();
    ctb_valid[0] = 1'b1;
    ctb_prf_int_index[0] = 6'd4;
    tick();
    idle();
    tick();
  endtask

  task automatic test_ctb_bypass();
    micro_op_t [DISPATCH_WIDTH-1:0] exp;
    idle();
    uop_in[0] = make_uop(1'b1, 1'b1, 6'd3, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0e00);
    tick();
    idle();
    uop_in[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd3, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0e01);
    ctb_valid[1] = 1'b1;
    ctb_prf_int_index[1] = 6'd3;
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd3, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0e01);
`ifdef DISPATCH_INT_CTB_BYPASS_EN
    exp[0].rs1_from_ctb = 1'b0;
`else
    exp[0].rs1_from_ctb = 1'b1;
`endif
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL ctb_bypass_load: got %h want %h", uop_out, exp);
    end
    idle();
    tick();
    uop_in[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd3, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0e02);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd3, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0e02);
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL ctb_bypass_after: got %h want %h", uop_out, exp);
    end
    idle();
    tick();
  endtask

  task automatic test_zero_index();
    micro_op_t [DISPATCH_WIDTH-1:0] exp;
    idle();
    uop_in[0] = make_uop(1'b1, 1'b1, 6'd0, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0f00);
    uop_in[1] = make_uop(1'b1, 1'b0, 6'd0, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0f01);
    tick();
    idle();
    uop_in[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0f02);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h0f02);
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL zero_index: got %h want %h", uop_out, exp);
    end
    idle();
    tick();
  endtask

  task automatic test_flush();
    micro_op_t [DISPATCH_WIDTH-1:0] exp;
    idle();
    uop_in[0] = make_uop(1'b1, 1'b1, 6'd14, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h1000);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b1, 6'd14, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h1000);
    idle();
    iq_int_full = 1'b1;
    tick();
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL flush_pre_hold: got %h want %h", uop_out, exp);
    end
    flush = 1'b1;
    tick();
    n_checks++;
    if (uop_out !== '0) begin
      n_fail++;
      $display("FAIL flush_held: got %h want 0", uop_out);
    end
    iq_int_full = 1'b0;
    uop_in[0] = make_uop(1'b1, 1'b1, 6'd12, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h10ee);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_in_ready: got %b want 1", in_ready);
    end
    tick();
    n_checks++;
    if (uop_out !== '0) begin
      n_fail++;
      $display("FAIL flush_discard: got %h want 0", uop_out);
    end
    // p12 never set (discarded); p14 still busy (flush leaves the table)
    idle();
    uop_in[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd12, RS_FROM_RF, 6'd14, RS_FROM_RF, 16'h1001);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd12, RS_FROM_RF, 6'd14, RS_FROM_RF, 16'h1001);
    exp[0].rs2_from_ctb = 1'b1;
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL flush_busy_kept: got %h want %h", uop_out, exp);
    end
    idle();
    ctb_valid[0] = 1'b1;
    ctb_prf_int_index[0] = 6'd14;
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_stall();
    micro_op_t [DISPATCH_WIDTH-1:0] exp;
    idle();
    uop_in[2] = make_uop(1'b1, 1'b1, 6'd13, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h1100);
    tick();
    exp = '0;
    exp[2] = make_uop(1'b1, 1'b1, 6'd13, 6'd0, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h1100);
    idle();
    iq_int_full = 1'b1;
    tick();
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL rst_stall_hold: got %h want %h", uop_out, exp);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (uop_out !== '0) begin
      n_fail++;
      $display("FAIL rst_async_clear: got %h want 0", uop_out);
    end
    tick();
    reset = 1'b1;
    iq_int_full = 1'b0;
    tick();
    tick();
    n_checks++;
    if (uop_out !== '0) begin
      n_fail++;
      $display("FAIL rst_no_delivery: got %h want 0", uop_out);
    end
    uop_in[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd13, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h1101);
    tick();
    exp = '0;
    exp[0] = make_uop(1'b1, 1'b0, 6'd0, 6'd13, RS_FROM_RF, 6'd0, RS_FROM_RF, 16'h1101);
    n_checks++;
    if (uop_out !== exp) begin
      n_fail++;
      $display("FAIL rst_busy_cleared: got %h want %h", uop_out, exp);
    end
    idle();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    iq_int_full = 1'b0;
    idle();
    test_reset();
    test_dep_busy();
    test_intra_group();
    test_stall_wakeup();
    test_set_wins();
    test_ctb_bypass();
    test_zero_index();
    test_flush();
    test_reset_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_int.md
DISPATCH_INT -- requirements
Module: dispatch_int

Interface
REQ-001 clock  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-003 uop_in  input  micro_op_t[DISPATCH_WIDTH]  renamed uops from rename; per-lane .valid; uses fields rd_valid, rd_prf_int_index, rs1/rs2_prf_int_index, rs1/rs2_source.
REQ-004 in_ready  output  1  dispatch_int accepts uop_in this cycle.
REQ-005 iq_int_full  input  1  issue_queue_int cannot take a DISPATCH_WIDTH group this cycle.
REQ-006 ctb_prf_int_index  input  [ISSUE_WIDTH_INT][PRF_INT_INDEX_SIZE]  common tag bus indices.
REQ-007 ctb_valid  input  ISSUE_WIDTH_INT  per-lane tag bus valid.
REQ-008 flush  input  1  synchronous pipeline flush (mispredict).
REQ-009 uop_out  output  micro_op_t[DISPATCH_WIDTH]  registered group to issue_queue_int, rs1/rs2_from_ctb resolved.

Function
REQ-010 Busy table: PRF_INT_SIZE bits; bit=1 means physical register value not yet broadcast on ctb.
REQ-011 Accept = in_ready & any uop_in[i].valid; in_ready = ~out_valid | ~iq_int_full, out_valid = OR of uop_out[i].valid.
REQ-012 On accept, uop_out loads uop_in at next edge; latency exactly 1 cycle; invalid lanes pass as all-zero uops.
REQ-013 While out_valid & iq_int_full, uop_out holds; it presents to issue_queue_int only when iq_int_full=0; group leaves register on that edge unless replaced by new accept.
REQ-014 rsN_from_ctb = (rsN_source==RS_FROM_RF) & busy[rsN_prf_int_index] & index!=0, evaluated on load.
REQ-015 Intra-group: lane j source matching rd_prf_int_index of valid lane i<j with rd_valid sets rsN_from_ctb=1 regardless of busy table.
REQ-016 While held, any ctb_valid[k] matching a held rsN index clears that rsN_from_ctb at next edge (no lost wakeup).
REQ-017 On accept, busy[rd_prf_int_index] set for each valid lane with rd_valid & index!=0.
REQ-018 ctb_valid[k] clears busy[ctb_prf_int_index[k]]; same-cycle set and clear on one index: set wins.
REQ-019 busy[0] reads 0 always; writes to index 0 ignored.
REQ-020 flush: uop_out cleared to 0 at next edge, in_ready still computed normally, uop_in that cycle discarded, busy table unaffected except ctb clears.

Reset
REQ-021 reset=0 asynchronously clears uop_out to 0 and all busy bits to 0; in_ready=1 after release.
REQ-022 Reset mid-stall drops the held group; no uop is delivered after reset deassertion without a new accept.

Configuration
REQ-023 Macro DISPATCH_INT_CTB_BYPASS_EN: defined -> same-cycle ctb_valid match on an rsN index at load forces rsN_from_ctb=0 (bypass of REQ-014); undefined -> REQ-014 uses registered busy only, issue_slot_int ctb compare at load covers the case.

Structure
REQ-024 DISPATCH_WIDTH, ISSUE_WIDTH_INT, PRF_INT_SIZE, PRF_INT_INDEX_SIZE, micro_op_t, RS_FROM_RF stay in micro_op.svh shared package.
REQ-025 One sub-module busy_table_int (PRF_INT_SIZE bits, DISPATCH_WIDTH set ports, ISSUE_WIDTH_INT clear ports, 2*DISPATCH_WIDTH read ports).

Verification
REQ-026 Lane0 rd=p5 accepted, next cycle lane0 rs1=p5 -> uop_out rs1_from_ctb=1; after ctb p5 valid, a new rs1=p5 -> rs1_from_ctb=0.
REQ-027 Same group lane0 rd=p7, lane2 rs2=p7 -> lane2 rs2_from_ctb=1 even though busy[7]=0 before.
REQ-028 iq_int_full=1 for 3 cycles with rs1=p9 busy, ctb p9 on cycle 2 -> uop_out held, in_ready=0, rs1_from_ctb drops to 0 on cycle 3, delivered when full=0.
REQ-029 Same cycle accept rd=p4 and ctb p4 valid -> busy[4]=1 afterwards.
REQ-030 flush while held group -> uop_out=0 next cycle; reset=0 mid-stall -> uop_out=0 and busy all 0 immediately.
REQ-031 With and without DISPATCH_INT_CTB_BYPASS_EN: load rs1=p3 busy with ctb p3 same cycle -> rs1_from_ctb 0 vs 1.
